// File: rtl/sdmac_reg_core.sv
// Register front end of the ReSDMAC: CPU access decode, CNTR/ISTR registers and
// the maskable interrupt output. All state advances on the falling edge of CLK.
module sdmac_reg_core (
  input  logic       CLK,
  input  logic       RST_,
  input  logic [7:0] ADDR,
  input  logic       DMAC_,
  input  logic       AS_,
  input  logic       RW,
  input  logic [8:0] MID,
  input  logic       FIFOEMPTY,
  input  logic       FIFOFULL,
  input  logic       INTA_I,
  output logic [8:0] CNTR_O,
  output logic [8:0] ISTR_O,
  output logic       INT_O_,
  output logic       INTENA,
  output logic       PRESET,
  output logic       DMADIR,
  output logic       DMAENA,
  output logic       WDREGREQ,
  output logic       h_0C,
  output logic       ACR_WR,
  output logic       WTC_RD_,
  output logic       CONTR_RD_,
  output logic       ISTR_RD_,
  output logic       SSPBDAT_RD_,
  output logic       VERSION_RD_,
  output logic       CONTR_WR,
  output logic       SSPBDAT_WR,
  output logic       VERSION_WR,
  output logic       ST_DMA,
  output logic       SP_DMA,
  output logic       CLR_INT,
  output logic       FLUSH_
);

  localparam logic [5:0] RegWtc     = 6'h01;
  localparam logic [5:0] RegCntr    = 6'h02;
  localparam logic [5:0] RegAcr     = 6'h03;
  localparam logic [5:0] RegStDma   = 6'h04;
  localparam logic [5:0] RegFlush   = 6'h05;
  localparam logic [5:0] RegClrInt  = 6'h06;
  localparam logic [5:0] RegIstr    = 6'h07;
  localparam logic [5:0] RegSpDma   = 6'h0F;
  localparam logic [5:0] RegSspbDat = 6'h17;
  localparam logic [5:0] RegVersion = 6'h18;

  logic [5:0] regAddr;
  logic       sel;
  logic       rdSel;
  logic       wrSel;

  logic dmaena_q, dmaena_d;
  logic tcen_q, tcen_d;
  logic preset_q, preset_d;
  logic pdmd_q, pdmd_d;
  logic intena_q, intena_d;
  logic dmadir_q, dmadir_d;
  logic intx_q, intx_d;
  logic intp_d;
  logic [8:0] istr_q, istr_d;
  logic int_o_q, int_o_d;

  logic unused_bits;
  assign unused_bits = ^{ADDR[1:0], MID[8:6], MID[0]};

  assign regAddr = ADDR[7:2];
  assign sel     = ~DMAC_ & ~AS_;
  assign rdSel   = sel & RW;
  assign wrSel   = sel & ~RW;

  // Address decode: every strobe is idle unless the chip is selected and strobed.
  always_comb begin
    WDREGREQ    = 1'b0;
    h_0C        = 1'b0;
    ACR_WR      = 1'b0;
    WTC_RD_     = 1'b1;
    CONTR_RD_   = 1'b1;
    ISTR_RD_    = 1'b1;
    SSPBDAT_RD_ = 1'b1;
    VERSION_RD_ = 1'b1;
    CONTR_WR    = 1'b0;
    SSPBDAT_WR  = 1'b0;
    VERSION_WR  = 1'b0;
    ST_DMA      = 1'b0;
    SP_DMA      = 1'b0;
    CLR_INT     = 1'b0;
    FLUSH_      = 1'b1;
    if (sel) begin
      case (regAddr)
        RegWtc:     WTC_RD_ = ~RW;
        RegCntr: begin
          CONTR_RD_ = ~rdSel;
          CONTR_WR  = wrSel;
        end
        RegAcr: begin
          h_0C   = 1'b1;
          ACR_WR = wrSel;
        end
        RegStDma:   ST_DMA  = 1'b1;
        RegFlush:   FLUSH_  = 1'b0;
        RegClrInt:  CLR_INT = 1'b1;
        RegIstr:    ISTR_RD_ = ~rdSel;
        RegSpDma:   SP_DMA  = 1'b1;
        RegSspbDat: begin
          SSPBDAT_RD_ = ~rdSel;
          SSPBDAT_WR  = wrSel;
        end
        RegVersion: begin
          VERSION_RD_ = ~rdSel;
          VERSION_WR  = wrSel;
        end
        default: WDREGREQ = (regAddr[5:2] == 4'b0100);
      endcase
    end
  end

  // Next-state for CNTR and ISTR; the interrupt terms use the post-edge INTENA
  // so INT_P, INTX and INT_O_ all change on the same falling edge.
  always_comb begin
    dmaena_d = dmaena_q;
    tcen_d   = tcen_q;
    preset_d = preset_q;
    pdmd_d   = pdmd_q;
    intena_d = intena_q;
    dmadir_d = dmadir_q;
    if (CONTR_WR) begin
      tcen_d   = MID[5];
      preset_d = MID[4];
      pdmd_d   = MID[3];
      intena_d = MID[2];
      dmadir_d = MID[1];
    end
    if (ST_DMA) begin
      dmaena_d = 1'b1;
    end else if (SP_DMA) begin
      dmaena_d = 1'b0;
    end

    intp_d  = INTA_I & intena_d;
    intx_d  = intp_d | (intx_q & ~CLR_INT);
    int_o_d = ~intp_d;

    istr_d = istr_q;
    if (ISTR_RD_) begin
      istr_d = {intx_d, INTA_I, INTA_I, 1'b0, intp_d, 1'b0, 1'b0, FIFOFULL, FIFOEMPTY};
    end
  end

  always_ff @(negedge CLK or negedge RST_) begin
    if (!RST_) begin
      dmaena_q <= 1'b0;
      tcen_q   <= 1'b0;
      preset_q <= 1'b0;
      pdmd_q   <= 1'b0;
      intena_q <= 1'b0;
      dmadir_q <= 1'b0;
      intx_q   <= 1'b0;
      istr_q   <= 9'h000;
      int_o_q  <= 1'b1;
    end else begin
      dmaena_q <= dmaena_d;
      tcen_q   <= tcen_d;
      preset_q <= preset_d;
      pdmd_q   <= pdmd_d;
      intena_q <= intena_d;
      dmadir_q <= dmadir_d;
      intx_q   <= intx_d;
      istr_q   <= istr_d;
      int_o_q  <= int_o_d;
    end
  end

  assign CNTR_O = {dmaena_q, 2'b00, tcen_q, preset_q, pdmd_q, intena_q, dmadir_q, 1'b0};
  assign ISTR_O = istr_q;
  assign INT_O_ = int_o_q;
  assign INTENA = intena_q;
  assign PRESET = preset_q;
  assign DMADIR = dmadir_q;
  assign DMAENA = dmaena_q;

endmodule

// File: tb/tb_sdmac_reg_core.sv
// Directed bench for sdmac_reg_core: reset, CNTR writes, DMA start/stop,
// interrupt set/clear, address decode sweep, ISTR snapshot and async reset.
module tb_sdmac_reg_core;

  logic       CLK;
  logic       RST_;
  logic [7:0] ADDR;
  logic       DMAC_;
  logic       AS_;
  logic       RW;
  logic [8:0] MID;
  logic       FIFOEMPTY;
  logic       FIFOFULL;
  logic       INTA_I;
  logic [8:0] CNTR_O;
  logic [8:0] ISTR_O;
  logic       INT_O_;
  logic       INTENA, PRESET, DMADIR, DMAENA;
  logic       WDREGREQ, h_0C, ACR_WR;
  logic       WTC_RD_, CONTR_RD_, ISTR_RD_, SSPBDAT_RD_, VERSION_RD_;
  logic       CONTR_WR, SSPBDAT_WR, VERSION_WR;
  logic       ST_DMA, SP_DMA, CLR_INT, FLUSH_;

  int total = 0;
  int bad   = 0;

  sdmac_reg_core dut (
    .CLK(CLK), .RST_(RST_), .ADDR(ADDR), .DMAC_(DMAC_), .AS_(AS_), .RW(RW),
    .MID(MID), .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL), .INTA_I(INTA_I),
    .CNTR_O(CNTR_O), .ISTR_O(ISTR_O), .INT_O_(INT_O_),
    .INTENA(INTENA), .PRESET(PRESET), .DMADIR(DMADIR), .DMAENA(DMAENA),
    .WDREGREQ(WDREGREQ), .h_0C(h_0C), .ACR_WR(ACR_WR),
    .WTC_RD_(WTC_RD_), .CONTR_RD_(CONTR_RD_), .ISTR_RD_(ISTR_RD_),
    .SSPBDAT_RD_(SSPBDAT_RD_), .VERSION_RD_(VERSION_RD_),
    .CONTR_WR(CONTR_WR), .SSPBDAT_WR(SSPBDAT_WR), .VERSION_WR(VERSION_WR),
    .ST_DMA(ST_DMA), .SP_DMA(SP_DMA), .CLR_INT(CLR_INT), .FLUSH_(FLUSH_)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobes folded into one vector where 1 always means "asserted".
  // [14]WDREGREQ [13]h_0C [12]ACR_WR [11]WTC_RD [10]CONTR_RD [9]ISTR_RD
  // [8]SSPBDAT_RD [7]VERSION_RD [6]CONTR_WR [5]SSPBDAT_WR [4]VERSION_WR
  // [3]ST_DMA [2]SP_DMA [1]CLR_INT [0]FLUSH
  logic [14:0] active;
  assign active = {WDREGREQ, h_0C, ACR_WR, ~WTC_RD_, ~CONTR_RD_, ~ISTR_RD_,
                   ~SSPBDAT_RD_, ~VERSION_RD_, CONTR_WR, SSPBDAT_WR, VERSION_WR,
                   ST_DMA, SP_DMA, CLR_INT, ~FLUSH_};

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One bus access spanning exactly one falling edge.
  task automatic applyStimulus(input logic [7:0] addr, input logic rw, input logic [8:0] mid);
    @(posedge CLK); #1;
    ADDR = addr; RW = rw; MID = mid; DMAC_ = 1'b0; AS_ = 1'b0;
    @(negedge CLK); #1;
    DMAC_ = 1'b1; AS_ = 1'b1;
  endtask

  task automatic idleEdge();
    @(negedge CLK); #1;
  endtask

  // Decode check inside the high phase, released before any falling edge.
  task automatic decodeCheck(input string tag, input logic [7:0] addr, input logic rw,
                             input logic cs_n, input logic [14:0] expected);
    @(posedge CLK); #1;
    ADDR = addr; RW = rw; DMAC_ = cs_n; AS_ = 1'b0;
    #2;
    checkOutput(tag, {1'b0, active}, {1'b0, expected});
    #1;
    DMAC_ = 1'b1; AS_ = 1'b1;
  endtask

  initial begin
    RST_ = 1'b0; ADDR = 8'h00; DMAC_ = 1'b1; AS_ = 1'b1; RW = 1'b1; MID = 9'h000;
    FIFOEMPTY = 1'b0; FIFOFULL = 1'b0; INTA_I = 1'b0;
    #23;
    checkOutput("rst_cntr", {7'd0, CNTR_O}, 16'h0000);
    checkOutput("rst_istr", {7'd0, ISTR_O}, 16'h0000);
    checkOutput("rst_into", {15'd0, INT_O_}, 16'h0001);
    checkOutput("rst_dmaena", {15'd0, DMAENA}, 16'h0000);
    checkOutput("rst_strobes", {1'b0, active}, 16'h0000);
    @(posedge CLK); #1;
    RST_ = 1'b1;

    applyStimulus(8'h08, 1'b0, 9'h1FE);
    checkOutput("cntr_wr", {7'd0, CNTR_O}, 16'h003E);
    checkOutput("cntr_bits", {12'd0, INTENA, PRESET, DMADIR, DMAENA}, 16'h000E);

    applyStimulus(8'h10, 1'b1, 9'h000);
    checkOutput("st_dma", {7'd0, CNTR_O}, 16'h013E);
    checkOutput("st_dmaena", {15'd0, DMAENA}, 16'h0001);
    applyStimulus(8'h3C, 1'b0, 9'h000);
    checkOutput("sp_dma", {7'd0, CNTR_O}, 16'h003E);

    FIFOEMPTY = 1'b1;
    INTA_I = 1'b1;
    idleEdge();
    checkOutput("int_set_istr", {7'd0, ISTR_O}, 16'h01D1);
    checkOutput("int_set_into", {15'd0, INT_O_}, 16'h0000);
    INTA_I = 1'b0;
    idleEdge();
    checkOutput("int_sticky", {7'd0, ISTR_O}, 16'h0101);
    checkOutput("int_drop_into", {15'd0, INT_O_}, 16'h0001);
    applyStimulus(8'h18, 1'b1, 9'h000);
    checkOutput("clr_int", {7'd0, ISTR_O}, 16'h0001);

    INTA_I = 1'b1;
    idleEdge();
    applyStimulus(8'h18, 1'b0, 9'h000);
    checkOutput("clr_vs_set", {7'd0, ISTR_O}, 16'h01D1);
    INTA_I = 1'b0;
    idleEdge();
    applyStimulus(8'h18, 1'b0, 9'h000);
    checkOutput("clr_int_wr", {7'd0, ISTR_O}, 16'h0001);

    applyStimulus(8'h08, 1'b0, 9'h000);
    checkOutput("cntr_clear", {7'd0, CNTR_O}, 16'h0000);
    INTA_I = 1'b1;
    idleEdge();
    checkOutput("masked_istr", {7'd0, ISTR_O}, 16'h00C1);
    checkOutput("masked_into", {15'd0, INT_O_}, 16'h0001);
    INTA_I = 1'b0;
    idleEdge();
    checkOutput("masked_drop", {7'd0, ISTR_O}, 16'h0001);

    applyStimulus(8'h10, 1'b0, 9'h000);
    checkOutput("st_dma_wr", {7'd0, CNTR_O}, 16'h0100);
    applyStimulus(8'h08, 1'b0, 9'h1FF);
    checkOutput("cntr_keeps_dma", {7'd0, CNTR_O}, 16'h013E);
    applyStimulus(8'h3C, 1'b1, 9'h000);
    checkOutput("sp_dma_rd", {7'd0, CNTR_O}, 16'h003E);

    decodeCheck("dec_04r", 8'h04, 1'b1, 1'b0, 15'h0800);
    decodeCheck("dec_04w", 8'h04, 1'b0, 1'b0, 15'h0000);
    decodeCheck("dec_08r", 8'h08, 1'b1, 1'b0, 15'h0400);
    decodeCheck("dec_0Br", 8'h0B, 1'b1, 1'b0, 15'h0400);
    decodeCheck("dec_08w", 8'h08, 1'b0, 1'b0, 15'h0040);
    decodeCheck("dec_0Cr", 8'h0C, 1'b1, 1'b0, 15'h2000);
    decodeCheck("dec_0Cw", 8'h0C, 1'b0, 1'b0, 15'h3000);
    decodeCheck("dec_10r", 8'h10, 1'b1, 1'b0, 15'h0008);
    decodeCheck("dec_10w", 8'h10, 1'b0, 1'b0, 15'h0008);
    decodeCheck("dec_14r", 8'h14, 1'b1, 1'b0, 15'h0001);
    decodeCheck("dec_14w", 8'h14, 1'b0, 1'b0, 15'h0001);
    decodeCheck("dec_18r", 8'h18, 1'b1, 1'b0, 15'h0002);
    decodeCheck("dec_18w", 8'h18, 1'b0, 1'b0, 15'h0002);
    decodeCheck("dec_1Cr", 8'h1C, 1'b1, 1'b0, 15'h0200);
    decodeCheck("dec_1Cw", 8'h1C, 1'b0, 1'b0, 15'h0000);
    decodeCheck("dec_3Cr", 8'h3C, 1'b1, 1'b0, 15'h0004);
    decodeCheck("dec_3Cw", 8'h3C, 1'b0, 1'b0, 15'h0004);
    decodeCheck("dec_40r", 8'h40, 1'b1, 1'b0, 15'h4000);
    decodeCheck("dec_44w", 8'h44, 1'b0, 1'b0, 15'h4000);
    decodeCheck("dec_4Fr", 8'h4F, 1'b1, 1'b0, 15'h4000);
    decodeCheck("dec_50r", 8'h50, 1'b1, 1'b0, 15'h0000);
    decodeCheck("dec_5Cr", 8'h5C, 1'b1, 1'b0, 15'h0100);
    decodeCheck("dec_5Cw", 8'h5C, 1'b0, 1'b0, 15'h0020);
    decodeCheck("dec_60r", 8'h60, 1'b1, 1'b0, 15'h0080);
    decodeCheck("dec_60w", 8'h60, 1'b0, 1'b0, 15'h0010);
    decodeCheck("dec_20r", 8'h20, 1'b1, 1'b0, 15'h0000);
    decodeCheck("dec_nocs", 8'h08, 1'b0, 1'b1, 15'h0000);
    checkOutput("dec_no_side_effect", {7'd0, CNTR_O}, 16'h003E);

    @(posedge CLK); #1;
    ADDR = 8'h1C; RW = 1'b1; DMAC_ = 1'b0; AS_ = 1'b0;
    idleEdge();
    FIFOFULL = 1'b1;
    idleEdge();
    checkOutput("snap_hold", {7'd0, ISTR_O}, 16'h0001);
    idleEdge();
    checkOutput("snap_hold2", {7'd0, ISTR_O}, 16'h0001);
    DMAC_ = 1'b1; AS_ = 1'b1;
    idleEdge();
    checkOutput("snap_resume", {7'd0, ISTR_O}, 16'h0003);

    INTA_I = 1'b1;
    applyStimulus(8'h10, 1'b1, 9'h000);
    checkOutput("pre_rst_istr", {7'd0, ISTR_O}, 16'h01D3);
    checkOutput("pre_rst_cntr", {7'd0, CNTR_O}, 16'h013E);
    @(posedge CLK); #1;
    RST_ = 1'b0;
    #1;
    checkOutput("async_rst_cntr", {7'd0, CNTR_O}, 16'h0000);
    checkOutput("async_rst_istr", {7'd0, ISTR_O}, 16'h0000);
    checkOutput("async_rst_into", {15'd0, INT_O_}, 16'h0001);
    INTA_I = 1'b0;
    @(posedge CLK); #1;
    RST_ = 1'b1;
    idleEdge();
    checkOutput("post_rst_istr", {7'd0, ISTR_O}, 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdmac_reg_core.md
Name: sdmac_reg_core

Overview:
Register front end of the ReSDMAC SCSI DMA controller. Decodes CPU register accesses into read-selects, write strobes and action strobes. Holds the Control Register (CNTR) and the Interrupt Status Register (ISTR), and drives the maskable interrupt output. Sits between the CPU bus interface and the DMA/FIFO/read-mux logic.

Parameters:
none

Ports:
CLK  in  1  system clock; all state updates on falling edge
RST_  in  1  reset; asynchronous, active-low
ADDR  in  8  CPU address A[7:0]; ADDR[1:0] ignored
DMAC_  in  1  chip select, active-low
AS_  in  1  address strobe, active-low
RW  in  1  1=read, 0=write
MID  in  9  write data bits [8:0]
FIFOEMPTY  in  1  FIFO empty flag
FIFOFULL  in  1  FIFO full flag
INTA_I  in  1  SCSI chip interrupt request, active-high
CNTR_O  out  9  control register readback
ISTR_O  out  9  interrupt status readback
INT_O_  out  1  interrupt output, active-low
INTENA, PRESET, DMADIR, DMAENA  out  1 each  CNTR decoded bits
WDREGREQ  out  1  WD33C93 register access
h_0C  out  1  ACR ($0C) selected, any direction
ACR_WR  out  1  ACR write
WTC_RD_, CONTR_RD_, ISTR_RD_, SSPBDAT_RD_, VERSION_RD_  out  1 each  read selects, active-low
CONTR_WR, SSPBDAT_WR, VERSION_WR  out  1 each  write strobes, active-high
ST_DMA, SP_DMA, CLR_INT  out  1 each  action strobes, active-high
FLUSH_  out  1  flush strobe, active-low

Behaviour:
- Decode (combinational): SEL = ~DMAC_ & ~AS_. With SEL low, every strobe is inactive: active-high low, active-low high.
- Address map on ADDR[7:2]:
  - $04 WTC: read only.
  - $08 CNTR: read and write.
  - $0C ACR: h_0C asserted for either direction; ACR_WR on write.
  - $10 ST_DMA, $14 FLUSH_, $18 CLR_INT, $3C SP_DMA: strobe on read or write.
  - $1C ISTR: read only.
  - $40-$4F: WDREGREQ, either direction.
  - $5C SSPBDAT, $60 VERSION: read and write.
  - Unmapped addresses assert nothing.
- Read selects require RW=1. Write strobes require RW=0.
- CNTR, bit layout:
  - bit 8 DMAENA.
  - bit 5 TCEN, bit 4 PRESET, bit 3 PDMD, bit 2 INTENA, bit 1 DMADIR (stored; non-inverted copy on the DMADIR port).
  - bits 7, 6, 0 read 0.
- CNTR update:
  - On a falling edge with CONTR_WR: bits[5:1] <= MID[5:1].
  - DMAENA set on a falling edge with ST_DMA, cleared on a falling edge with SP_DMA.
  - CONTR_WR does not affect DMAENA.
- CNTR reset: all bits 0.
- ISTR, bit layout:
  - bit 8 INTX, bit 7 INT_F, bit 6 INTS, bit 5 E_INT, bit 4 INT_P, bit 3 UE_INT, bit 2 OE_INT, bit 1 FF_FLG, bit 0 FE_FLG.
- ISTR register rules:
  - INTS: INTA_I registered on the falling edge.
  - E_INT, UE_INT, OE_INT: constant 0.
  - INT_F = INTS | E_INT.
  - INT_P = INT_F & INTENA.
  - INTX: sticky. Set on a falling edge when INT_P=1. Cleared on a falling edge with CLR_INT.
  - CLR_INT and INT_P in the same edge: set wins.
  - FF_FLG = FIFOFULL, FE_FLG = FIFOEMPTY, both sampled on the falling edge.
- ISTR snapshot: while ISTR_RD_=0, ISTR_O holds its value from the last falling edge before ISTR_RD_ went low. It resumes tracking after ISTR_RD_ returns high.
- INT_O_ = ~INT_P, registered. INTENA=0 forces INT_O_=1.
- ISTR reset: all 0, INT_O_=1. Asserting RST_ mid-operation clears everything immediately.

Test Plan:
- Reset: RST_=0 -> CNTR_O=0, ISTR_O=0, INT_O_=1, DMAENA=0, all strobes inactive.
- Write CNTR: DMAC_=0, AS_=0, RW=0, ADDR=$08, MID=9'h1FE -> after falling edge CNTR_O=9'h03E, INTENA=1, PRESET=1, DMADIR=1, DMAENA=0.
- DMA start/stop: access ADDR=$10 (read) -> DMAENA=1, CNTR_O[8]=1. Access ADDR=$3C (write) -> DMAENA=0.
- Interrupt: INTENA=1, INTA_I=1 -> next falling edge ISTR_O bits 8,7,6,4 set (9'h1D0 | FIFO flags), INT_O_=0. INTA_I=0, then access $18 -> INTX cleared, INT_O_=1. Same sequence with INTENA=0 -> INT_O_ stays 1, INT_P=0, INTS=1.
- Decode sweep: each mapped address in both RW values -> exactly the listed strobe(s) active. ADDR=$44 -> WDREGREQ=1. ADDR=$0C write -> h_0C=1, ACR_WR=1. DMAC_=1 -> nothing asserted.
- Snapshot: hold ISTR_RD_ low (read $1C), toggle FIFOFULL -> ISTR_O[1] unchanged until AS_ deasserts.
